seven_seg_scan_decoder: RTL

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

---
 rtl/seven_seg_scan_decoder_if.sv | 23 ++
 rtl/seven_seg_scan_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder_if.sv
// Bundles the scanned seven-segment pins and the decoded results.
// The decoder takes the slave side; whatever drives the pins takes the master side.
interface seven_seg_scan_decoder_if;
    logic [7:0] seg_in;
    logic [1:0] sel_in;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] value;
    logic       value_valid;
    logic       update;
    logic       pattern_err;
    logic       timeout;

    modport slave (
        input  seg_in, sel_in,
        output tens, ones, value, value_valid, update, pattern_err, timeout
    );

    modport master (
        output seg_in, sel_in,
        input  tens, ones, value, value_valid, update, pattern_err, timeout
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a two-digit number from a multiplexed common-anode seven-segment display.
// The pins are sampled, debounced and decoded into digits, and a value is published once both digits have been seen.
module seven_seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    seven_seg_scan_decoder_if.slave   bus
);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    // Maps an active-low pattern to {legal, digit}; a lit decimal point makes the pattern illegal.
    function automatic logic [4:0] decode_seg(input logic [7:0] pat);
        case (pat)
            8'hC0:   decode_seg = {1'b1, 4'd0};
            8'hF9:   decode_seg = {1'b1, 4'd1};
            8'hA4:   decode_seg = {1'b1, 4'd2};
            8'hB0:   decode_seg = {1'b1, 4'd3};
            8'h99:   decode_seg = {1'b1, 4'd4};
            8'h92:   decode_seg = {1'b1, 4'd5};
            8'h82:   decode_seg = {1'b1, 4'd6};
            8'hF8:   decode_seg = {1'b1, 4'd7};
            8'h80:   decode_seg = {1'b1, 4'd8};
            8'h90:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    logic [7:0]      seg_s1_q, seg_s2_q;
    logic [1:0]      sel_s1_q, sel_s2_q;
    logic [9:0]      samp_prev_q;
    logic [7:0]      stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      tens_hold_q, tens_hold_d, ones_hold_q, ones_hold_d;
    logic            tens_seen_q, tens_seen_d, ones_seen_q, ones_seen_d;
    logic [3:0]      tens_q, tens_d, ones_q, ones_d;
    logic [6:0]      value_q, value_d;
    logic            valid_q, valid_d, update_q, update_d, err_q, err_d, timeout_q, timeout_d;

    logic [9:0]      samp_s;
    logic            same_s, accept_s, legal_tens_s, legal_ones_s, legal_acc_s;
    logic            publish_s, to_hit_s;
    logic [4:0]      dec_s;
    logic [6:0]      value_new_s;

    // Debounce, decode, frame assembly, timeout and publish next-state logic.
    always_comb begin
        samp_s       = {sel_s2_q, seg_s2_q};
        same_s       = (samp_s == samp_prev_q);
        dec_s        = decode_seg(seg_s2_q);
        // The run length saturates so that a long stable run accepts only once.
        if (!same_s) begin
            stab_cnt_d = 8'd1;
        end else if (stab_cnt_q < STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        accept_s     = same_s && (stab_cnt_q == (STAB_MAX - 8'd1));
        legal_ones_s = accept_s && (sel_s2_q == 2'b10) && dec_s[4];
        legal_tens_s = accept_s && (sel_s2_q == 2'b01) && dec_s[4];
        legal_acc_s  = legal_ones_s || legal_tens_s;
        err_d        = accept_s && ((sel_s2_q == 2'b00) ||
                       (((sel_s2_q == 2'b10) || (sel_s2_q == 2'b01)) && !dec_s[4]));
        publish_s    = tens_seen_q && ones_seen_q;
        value_new_s  = ({3'b000, tens_hold_q} * 7'd10) + {3'b000, ones_hold_q};
        to_hit_s     = !legal_acc_s && (to_cnt_q == (TO_MAX - TO_ONE));

        if (legal_acc_s) begin
            to_cnt_d = '0;
        end else if (to_cnt_q < TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (legal_tens_s) begin
            tens_hold_d = dec_s[3:0];
        end else begin
            tens_hold_d = tens_hold_q;
        end
        if (legal_ones_s) begin
            ones_hold_d = dec_s[3:0];
        end else begin
            ones_hold_d = ones_hold_q;
        end

        // A fresh accept wins over the clear so no digit is ever lost.
        if (legal_tens_s) begin
            tens_seen_d = 1'b1;
        end else if (publish_s || to_hit_s) begin
            tens_seen_d = 1'b0;
        end else begin
            tens_seen_d = tens_seen_q;
        end
        if (legal_ones_s) begin
            ones_seen_d = 1'b1;
        end else if (publish_s || to_hit_s) begin
            ones_seen_d = 1'b0;
        end else begin
            ones_seen_d = ones_seen_q;
        end

        if (publish_s) begin
            tens_d    = tens_hold_q;
            ones_d    = ones_hold_q;
            value_d   = value_new_s;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            update_d  = (value_new_s != value_q) || !valid_q;
        end else if (to_hit_s) begin
            tens_d    = tens_q;
            ones_d    = ones_q;
            value_d   = value_q;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            update_d  = 1'b0;
        end else begin
            tens_d    = tens_q;
            ones_d    = ones_q;
            value_d   = value_q;
            valid_d   = valid_q;
            timeout_d = timeout_q;
            update_d  = 1'b0;
        end
    end

    // Synchronizers, debounce history and all decoder state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= 8'hFF;
            seg_s2_q    <= 8'hFF;
            sel_s1_q    <= 2'b11;
            sel_s2_q    <= 2'b11;
            samp_prev_q <= {2'b11, 8'hFF};
            stab_cnt_q  <= 8'd0;
            to_cnt_q    <= '0;
            tens_hold_q <= 4'd0;
            ones_hold_q <= 4'd0;
            tens_seen_q <= 1'b0;
            ones_seen_q <= 1'b0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            value_q     <= 7'd0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            seg_s1_q    <= bus.seg_in;
            seg_s2_q    <= seg_s1_q;
            sel_s1_q    <= bus.sel_in;
            sel_s2_q    <= sel_s1_q;
            samp_prev_q <= samp_s;
            stab_cnt_q  <= stab_cnt_d;
            to_cnt_q    <= to_cnt_d;
            tens_hold_q <= tens_hold_d;
            ones_hold_q <= ones_hold_d;
            tens_seen_q <= tens_seen_d;
            ones_seen_q <= ones_seen_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.tens        = tens_q;
    assign bus.ones        = ones_q;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.pattern_err = err_q;
    assign bus.timeout     = timeout_q;
endmodule
